pll_lock_controller: RTL and testbench

//  Sequences the digital PLL loop: holds the loop filter cleared at start-up, runs it with a

---
 rtl/pll_lock_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_pll_lock_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_controller.sv
// pll_lock_controller
// Sequences the digital PLL loop filter: holds it cleared after enable, runs it with a
// short count limit while acquiring, and switches to a long limit once enough consecutive
// quiet measurement windows have been seen. A busy window while locked re-acquires.
module pll_lock_controller #(
  parameter int unsigned WINDOW_LEN   = 1024,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ACQ_LIMIT    = 8,
  parameter int unsigned TRK_LIMIT    = 64,
  parameter int unsigned LOCK_MAX     = 2,
  parameter int unsigned LOCK_WINDOWS = 4,
  parameter int unsigned UNLOCK_MIN   = 8,
  parameter int unsigned SETTLE_LEN   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             positiveShift_i,
  input  logic             negativeShift_i,
  output logic             filterClear_o,
  output logic [CNT_W-1:0] filterLimit_o,
  output logic             locked_o,
  output logic             lockLost_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  localparam int unsigned WIN_W   = $clog2(WINDOW_LEN);
  localparam int unsigned SET_W   = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
  localparam int unsigned QUIET_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WIN_W-1:0]   WIN_LAST     = WIN_W'(WINDOW_LEN - 1);
  localparam logic [SET_W-1:0]   SETTLE_LAST  = SET_W'(SETTLE_LEN - 1);
  localparam logic [QUIET_W-1:0] QUIET_TARGET = QUIET_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   LIM_ACQ      = CNT_W'(ACQ_LIMIT);
  localparam logic [CNT_W-1:0]   LIM_TRK      = CNT_W'(TRK_LIMIT);

  // Saturating +1: the shift counter must stick at all-ones rather than wrap,
  // otherwise a very noisy window could alias to a quiet-looking count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             inc);
    logic [CNT_W-1:0] result;
    if (inc && (value != CNT_MAX)) begin
      result = value + CNT_W'(1);
    end else begin
      result = value;
    end
    return result;
  endfunction

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
  logic [QUIET_W-1:0] quiet_cnt_q, quiet_cnt_d;

  logic               filter_clear_q, filter_clear_d;
  logic [CNT_W-1:0]   filter_limit_q, filter_limit_d;
  logic               locked_q, locked_d;
  logic               lock_lost_q, lock_lost_d;

  logic               pulse_s;
  logic               win_end_s;
  logic [CNT_W-1:0]   total_s;
  logic [QUIET_W-1:0] quiet_inc_s;

  // A window-end pulse belongs to the closing window, so the window total
  // folds in the current cycle's pulse before the counter is restarted.
  always_comb begin
    pulse_s     = positiveShift_i | negativeShift_i;
    win_end_s   = (win_cnt_q == WIN_LAST);
    total_s     = sat_inc(shift_cnt_q, pulse_s);
    quiet_inc_s = quiet_cnt_q + QUIET_W'(1);
  end

  // Next-state and counter update; disable overrides every transition.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    shift_cnt_d  = shift_cnt_q;
    quiet_cnt_d  = quiet_cnt_q;
    lock_lost_d  = 1'b0;

    if (!enable_i) begin
      state_d      = ST_IDLE;
      settle_cnt_d = {SET_W{1'b0}};
      win_cnt_d    = {WIN_W{1'b0}};
      shift_cnt_d  = {CNT_W{1'b0}};
      quiet_cnt_d  = {QUIET_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_CLEAR;
          settle_cnt_d = {SET_W{1'b0}};
          win_cnt_d    = {WIN_W{1'b0}};
          shift_cnt_d  = {CNT_W{1'b0}};
          quiet_cnt_d  = {QUIET_W{1'b0}};
        end

        ST_CLEAR: begin
          win_cnt_d   = {WIN_W{1'b0}};
          shift_cnt_d = {CNT_W{1'b0}};
          quiet_cnt_d = {QUIET_W{1'b0}};
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = ST_ACQUIRE;
            settle_cnt_d = {SET_W{1'b0}};
          end else begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end

        ST_ACQUIRE: begin
          if (win_end_s) begin
            win_cnt_d   = {WIN_W{1'b0}};
            shift_cnt_d = {CNT_W{1'b0}};
            if (32'(total_s) <= LOCK_MAX) begin
              if (quiet_inc_s >= QUIET_TARGET) begin
                state_d     = ST_LOCKED;
                quiet_cnt_d = {QUIET_W{1'b0}};
              end else begin
                quiet_cnt_d = quiet_inc_s;
              end
            end else begin
              quiet_cnt_d = {QUIET_W{1'b0}};
            end
          end else begin
            win_cnt_d   = win_cnt_q + WIN_W'(1);
            shift_cnt_d = total_s;
          end
        end

        ST_LOCKED: begin
          if (win_end_s) begin
            win_cnt_d   = {WIN_W{1'b0}};
            shift_cnt_d = {CNT_W{1'b0}};
            if (32'(total_s) >= UNLOCK_MIN) begin
              state_d      = ST_CLEAR;
              settle_cnt_d = {SET_W{1'b0}};
              quiet_cnt_d  = {QUIET_W{1'b0}};
              lock_lost_d  = 1'b1;
            end else begin
              state_d = ST_LOCKED;
            end
          end else begin
            win_cnt_d   = win_cnt_q + WIN_W'(1);
            shift_cnt_d = total_s;
          end
        end

        default: begin
          state_d      = ST_IDLE;
          settle_cnt_d = {SET_W{1'b0}};
          win_cnt_d    = {WIN_W{1'b0}};
          shift_cnt_d  = {CNT_W{1'b0}};
          quiet_cnt_d  = {QUIET_W{1'b0}};
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    filter_clear_d = 1'b1;
    filter_limit_d = LIM_ACQ;
    locked_d       = 1'b0;
    case (state_d)
      ST_IDLE: begin
        filter_clear_d = 1'b1;
        filter_limit_d = LIM_ACQ;
        locked_d       = 1'b0;
      end
      ST_CLEAR: begin
        filter_clear_d = 1'b1;
        filter_limit_d = LIM_ACQ;
        locked_d       = 1'b0;
      end
      ST_ACQUIRE: begin
        filter_clear_d = 1'b0;
        filter_limit_d = LIM_ACQ;
        locked_d       = 1'b0;
      end
      ST_LOCKED: begin
        filter_clear_d = 1'b0;
        filter_limit_d = LIM_TRK;
        locked_d       = 1'b1;
      end
      default: begin
        filter_clear_d = 1'b1;
        filter_limit_d = LIM_ACQ;
        locked_d       = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset forces the parked IDLE values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= ST_IDLE;
      settle_cnt_q   <= {SET_W{1'b0}};
      win_cnt_q      <= {WIN_W{1'b0}};
      shift_cnt_q    <= {CNT_W{1'b0}};
      quiet_cnt_q    <= {QUIET_W{1'b0}};
      filter_clear_q <= 1'b1;
      filter_limit_q <= LIM_ACQ;
      locked_q       <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      win_cnt_q      <= win_cnt_d;
      shift_cnt_q    <= shift_cnt_d;
      quiet_cnt_q    <= quiet_cnt_d;
      filter_clear_q <= filter_clear_d;
      filter_limit_q <= filter_limit_d;
      locked_q       <= locked_d;
      lock_lost_q    <= lock_lost_d;
    end
  end

  assign filterClear_o = filter_clear_q;
  assign filterLimit_o = filter_limit_q;
  assign locked_o      = locked_q;
  assign lockLost_o    = lock_lost_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_controller.sv
// Directed bench for pll_lock_controller: window/lock timing, quiet-run reset, loss of lock,
// simultaneous shift pulses, counter saturation, disable override and asynchronous reset.
module tb_pll_lock_controller;

  logic       clk_i = 1'b0;
  logic       reset_i, enable_i, pos_i, neg_i;
  logic       filter_clear_o, locked_o, lock_lost_o;
  logic [7:0] filter_limit_o;
  logic [1:0] state_o;

  logic       enable_s_i, pos_s_i;
  logic       filter_clear_s_o, locked_s_o, lock_lost_s_o;
  logic [7:0] filter_limit_s_o;
  logic [1:0] state_s_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pll_lock_controller #(
    .WINDOW_LEN(16), .CNT_W(8), .ACQ_LIMIT(8), .TRK_LIMIT(64),
    .LOCK_MAX(2), .LOCK_WINDOWS(2), .UNLOCK_MIN(4), .SETTLE_LEN(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .positiveShift_i(pos_i), .negativeShift_i(neg_i),
    .filterClear_o(filter_clear_o), .filterLimit_o(filter_limit_o),
    .locked_o(locked_o), .lockLost_o(lock_lost_o), .state_o(state_o)
  );

  pll_lock_controller #(
    .WINDOW_LEN(512), .CNT_W(8), .ACQ_LIMIT(8), .TRK_LIMIT(64),
    .LOCK_MAX(2), .LOCK_WINDOWS(2), .UNLOCK_MIN(4), .SETTLE_LEN(4)
  ) dut_s (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_s_i),
    .positiveShift_i(pos_s_i), .negativeShift_i(1'b0),
    .filterClear_o(filter_clear_s_o), .filterLimit_o(filter_limit_s_o),
    .locked_o(locked_s_o), .lockLost_o(lock_lost_s_o), .state_o(state_s_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int clr, input int lim,
                         input int lck, input int lost);
    chk({tag, ".state"}, 32'(state_o), st);
    chk({tag, ".clear"}, 32'(filter_clear_o), clr);
    chk({tag, ".limit"}, 32'(filter_limit_o), lim);
    chk({tag, ".locked"}, 32'(locked_o), lck);
    chk({tag, ".lost"}, 32'(lock_lost_o), lost);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Drive one full 16-cycle window starting at window count 0. Pulses go on even
  // cycles from 0; with last=1 one of them is moved onto the window-end cycle.
  task automatic run_window(input int npulses, input bit last);
    int early;
    early = last ? npulses - 1 : npulses;
    for (int i = 0; i < 16; i++) begin
      pos_i = ((i < 2 * early) && (i % 2 == 0)) || (last && (i == 15));
      tick(1);
    end
    pos_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_i    = 1'b0;
    enable_i   = 1'b0;
    pos_i      = 1'b0;
    neg_i      = 1'b0;
    enable_s_i = 1'b0;
    pos_s_i    = 1'b0;

    tick(2);
    chk_out("reset", 0, 1, 8, 0, 0);
    reset_i = 1'b1;
    tick(1);
    chk_out("idle_disabled", 0, 1, 8, 0, 0);

    // Lock timing with no shifts: CLEAR for 4 cycles, two quiet windows of 16.
    enable_i = 1'b1;
    tick(1);
    chk_out("clear_entry", 1, 1, 8, 0, 0);
    tick(3);
    chk_out("clear_last", 1, 1, 8, 0, 0);
    tick(1);
    chk_out("acquire_entry", 2, 0, 8, 0, 0);
    tick(31);
    chk_out("before_lock", 2, 0, 8, 0, 0);
    tick(1);
    chk_out("lock_edge", 3, 0, 64, 1, 0);

    // Locked: 3 shifts (one on window end) stay locked; 4 shifts lose lock.
    run_window(3, 1'b1);
    chk_out("locked_3", 3, 0, 64, 1, 0);
    run_window(4, 1'b1);
    chk_out("unlock_4", 1, 1, 8, 0, 1);
    tick(1);
    chk_out("unlock_pulse_end", 1, 1, 8, 0, 0);
    tick(3);
    chk_out("reacquire", 2, 0, 8, 0, 0);

    // Acquire with 3 shifts per window never locks (end-cycle pulse counted).
    run_window(3, 1'b1);
    chk("busy3_w1.state", 32'(state_o), 2);
    run_window(3, 1'b0);
    chk("busy3_w2.state", 32'(state_o), 2);
    run_window(3, 1'b0);
    chk("busy3_w3.state", 32'(state_o), 2);
    // 2 shifts per window is quiet: lock after the second one.
    run_window(2, 1'b0);
    chk("quiet2_w1.state", 32'(state_o), 2);
    run_window(2, 1'b1);
    chk_out("quiet2_lock", 3, 0, 64, 1, 0);

    // Lose lock with 5 shifts, then quiet / busy / quiet / quiet.
    run_window(5, 1'b0);
    chk_out("unlock_5", 1, 1, 8, 0, 1);
    tick(4);
    chk("reacq2.state", 32'(state_o), 2);
    run_window(0, 1'b0);
    chk("qbq_quiet1.state", 32'(state_o), 2);
    run_window(5, 1'b0);
    chk("qbq_busy.state", 32'(state_o), 2);
    run_window(0, 1'b0);
    chk("qbq_quiet2.state", 32'(state_o), 2);
    chk("qbq_quiet2.locked", 32'(locked_o), 0);
    run_window(0, 1'b0);
    chk_out("qbq_lock", 3, 0, 64, 1, 0);

    // Both shift inputs high for 3 cycles counts 3, so the lock holds.
    pos_i = 1'b1;
    neg_i = 1'b1;
    tick(3);
    pos_i = 1'b0;
    neg_i = 1'b0;
    chk("both_high.count", 32'(dut.shift_cnt_q), 3);
    tick(13);
    chk_out("both_high_end", 3, 0, 64, 1, 0);

    // Disable on a window end that would lose lock: IDLE wins, no lockLost_o.
    for (int i = 0; i < 15; i++) begin
      pos_i = (i < 8) && (i % 2 == 0);
      tick(1);
    end
    pos_i    = 1'b1;
    enable_i = 1'b0;
    tick(1);
    pos_i = 1'b0;
    chk_out("disable_locked", 0, 1, 8, 0, 0);
    tick(1);
    chk_out("disable_hold", 0, 1, 8, 0, 0);

    // Asynchronous reset mid-ACQUIRE.
    enable_i = 1'b1;
    tick(5);
    chk("pre_reset.state", 32'(state_o), 2);
    tick(5);
    reset_i = 1'b0;
    #1;
    chk_out("async_reset", 0, 1, 8, 0, 0);
    tick(1);
    chk_out("async_reset_hold", 0, 1, 8, 0, 0);
    reset_i  = 1'b1;
    enable_i = 1'b0;
    tick(1);

    // Saturation: 300 consecutive pulses in a 512-cycle window stick at 255.
    enable_s_i = 1'b1;
    tick(5);
    chk("sat_acquire.state", 32'(state_s_o), 2);
    pos_s_i = 1'b1;
    tick(300);
    pos_s_i = 1'b0;
    chk("sat.count", 32'(dut_s.shift_cnt_q), 255);
    tick(2);
    chk("sat_hold.count", 32'(dut_s.shift_cnt_q), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
